io_fabric: RTL and testbench

IO_FABRIC -- requirements
Module: io_fabric

---
 rtl/io_fabric.sv | 188 ++++++++++++++++++
 tb/tb_io_fabric.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/io_fabric.sv
// rtl/io_fabric.sv - CPU I/O window decoder with slot select, ack/timeout FSM and error-status register
module io_fabric #(
  parameter int                NSLOTS   = 8,
  parameter logic [17:0]       IO_BASE  = 18'h3FFFF,
  parameter logic [NSLOTS-1:0] ACK_MASK = {NSLOTS{1'b0}},
  parameter int                TMO      = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [23:0]          adr,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  output logic                 io_en,
  output logic                 io_wait,
  output logic [NSLOTS-1:0]    slv_en,
  output logic                 slv_rd,
  output logic                 slv_wr,
  output logic [31:0]          slv_dout,
  input  logic [NSLOTS*32-1:0] slv_din,
  input  logic [NSLOTS-1:0]    slv_ack
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // The top slot is the internal error-status register, never a bus slot.
  localparam logic [3:0]  ESR_IDX = 4'(NSLOTS - 1);
  // Ack mask padded to the full 16-slot address space so any slot index is legal.
  localparam logic [15:0] ACK16   = 16'(ACK_MASK);
  localparam logic [7:0]  TMO8    = 8'(TMO);

  state_t      state, state_nx;
  logic [3:0]  slot;
  logic [3:0]  sel;
  logic [7:0]  cnt;
  logic [31:0] rdata;
  logic        req, mapped, is_esr, ext, ack_slot;
  logic [31:0] slot_data, sel_data;
  logic        sel_ack;
  logic        en_on;
  logic [3:0]  en_slot;
  logic        timeout;
  logic        esr_valid;
  logic [3:0]  esr_slot;
  logic [7:0]  esr_count;
  logic [31:0] esr;
  logic        unmapped_err, err_event, esr_clr;
  logic [3:0]  err_slot;
  logic        unused_ok;

  assign unused_ok = ^adr[1:0];

  assign io_en    = (adr[23:6] == IO_BASE);
  assign slot     = adr[5:2];
  assign req      = io_en & (rd | wr);
  assign mapped   = ({1'b0, slot} < 5'(NSLOTS));
  assign is_esr   = (slot == ESR_IDX);
  assign ext      = mapped & ~is_esr;
  assign ack_slot = ext & ACK16[slot];
  assign slv_dout = din;
  assign esr      = {esr_valid, 19'b0, esr_slot, esr_count};

  // Read-data and ack multiplexers for the addressed slot and the latched slot.
  always_comb begin
    slot_data = '0;
    sel_data  = '0;
    sel_ack   = 1'b0;
    for (int i = 0; i < NSLOTS; i++) begin
      if (slot == 4'(i)) slot_data = slv_din[32*i +: 32];
      if (sel == 4'(i)) begin
        sel_data = slv_din[32*i +: 32];
        sel_ack  = slv_ack[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, stall, strobes and CPU read data.
  always_comb begin
    state_nx = state;
    io_wait  = 1'b0;
    slv_rd   = 1'b0;
    slv_wr   = 1'b0;
    en_on    = 1'b0;
    en_slot  = sel;
    dout     = '0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        en_slot = slot;
        if (io_en) dout = ext ? slot_data : (is_esr ? esr : 32'h0);
        if (req) begin
          // A simultaneous rd and wr is a write.
          slv_wr = wr;
          slv_rd = rd & ~wr;
          en_on  = ext;
          if (ack_slot) begin
            io_wait  = 1'b1;
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        en_on   = 1'b1;
        io_wait = 1'b1;
        // Ack wins over a timeout landing on the same cycle.
        if (sel_ack) begin
          state_nx = DONE;
        end else if ((cnt + 8'd1) == TMO8) begin
          timeout  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        dout     = rdata;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (rst) begin
      io_wait = 1'b0;
      slv_rd  = 1'b0;
      slv_wr  = 1'b0;
      en_on   = 1'b0;
      timeout = 1'b0;
    end
  end

  // One-hot slot select; the ESR position is never driven.
  always_comb begin
    slv_en = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      slv_en[i] = en_on && (en_slot == 4'(i)) && (i != NSLOTS - 1);
    end
  end

  // Wait counter, latched slot and completion data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      sel   <= '0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req && ack_slot) sel <= slot;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (sel_ack)      rdata <= sel_data;
          else if (timeout) rdata <= '0;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign unmapped_err = (state == IDLE) && req && !mapped;
  assign err_event    = unmapped_err | timeout;
  assign err_slot     = timeout ? sel : slot;
  assign esr_clr      = (state == IDLE) && io_en && wr && is_esr;

  // Error-status register: sticky valid, first slot frozen, saturating count.
  always_ff @(posedge clk) begin
    if (rst) begin
      esr_valid <= 1'b0;
      esr_slot  <= '0;
      esr_count <= '0;
    end else if (err_event) begin
      esr_valid <= 1'b1;
      if (esr_clr || !esr_valid) esr_slot <= err_slot;
      if (esr_clr)                 esr_count <= 8'd1;
      else if (esr_count != 8'hFF) esr_count <= esr_count + 8'd1;
    end else if (esr_clr) begin
      esr_valid <= 1'b0;
      esr_slot  <= '0;
      esr_count <= '0;
    end
  end

endmodule

// File: tb/tb_io_fabric.sv
// tb/tb_io_fabric.sv - directed self-checking bench for io_fabric
module tb_io_fabric;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  din;

  logic [23:0]  adr_a;
  logic         rd_a, wr_a;
  logic [31:0]  dout_a, slv_dout_a;
  logic         io_en_a, io_wait_a, slv_rd_a, slv_wr_a;
  logic [7:0]   slv_en_a, slv_ack_a;
  logic [255:0] slv_din_a;

  logic [23:0]  adr_b;
  logic         rd_b, wr_b;
  logic [31:0]  dout_b, slv_dout_b;
  logic         io_en_b, io_wait_b, slv_rd_b, slv_wr_b;
  logic [5:0]   slv_en_b, slv_ack_b;
  logic [191:0] slv_din_b;

  int checks = 0;
  int errors = 0;
  int nwait, nrd;
  logic [31:0] dend;

  always #5 clk = ~clk;

  io_fabric #(.NSLOTS(8), .ACK_MASK(8'h10), .TMO(15)) u_a (
    .clk(clk), .rst(rst), .adr(adr_a), .rd(rd_a), .wr(wr_a), .din(din),
    .dout(dout_a), .io_en(io_en_a), .io_wait(io_wait_a), .slv_en(slv_en_a),
    .slv_rd(slv_rd_a), .slv_wr(slv_wr_a), .slv_dout(slv_dout_a),
    .slv_din(slv_din_a), .slv_ack(slv_ack_a)
  );

  io_fabric #(.NSLOTS(6)) u_b (
    .clk(clk), .rst(rst), .adr(adr_b), .rd(rd_b), .wr(wr_b), .din(din),
    .dout(dout_b), .io_en(io_en_b), .io_wait(io_wait_b), .slv_en(slv_en_b),
    .slv_rd(slv_rd_b), .slv_wr(slv_wr_b), .slv_dout(slv_dout_b),
    .slv_din(slv_din_b), .slv_ack(slv_ack_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc_a(input logic [23:0] a, input logic r, input logic w);
    @(posedge clk); #1;
    adr_a = a; rd_a = r; wr_a = w;
    @(negedge clk);
  endtask

  task automatic cyc_b(input logic [23:0] a, input logic r, input logic w);
    @(posedge clk); #1;
    adr_b = a; rd_b = r; wr_b = w;
    @(negedge clk);
  endtask

  // Read held until io_wait drops; slot 4 ack driven in cycle ack_at (request cycle = 0).
  task automatic run_a(input logic [23:0] a, input int ack_at, input logic [7:0] noise,
                       output int nw, output int nr, output logic [31:0] de);
    nw = 0; nr = 0; de = 32'hDEADBEEF;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin adr_a = a; rd_a = 1'b1; wr_a = 1'b0; end
      slv_ack_a = (c == ack_at) ? (noise | 8'h10) : noise;
      @(negedge clk);
      if (slv_rd_a) nr++;
      if (!io_wait_a) begin
        de = dout_a;
        break;
      end
      nw++;
    end
    @(posedge clk); #1;
    rd_a = 1'b0; slv_ack_a = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = 32'hCAFEF00D;
    adr_a = 24'hFFFFD0; rd_a = 1'b1; wr_a = 1'b0; slv_ack_a = '0;
    adr_b = 24'h0; rd_b = 1'b0; wr_b = 1'b0; slv_ack_b = '0; slv_din_b = '0;
    slv_din_a = '0;
    slv_din_a[31:0]    = 32'h12345678;
    slv_din_a[95:64]   = 32'h22222222;
    slv_din_a[159:128] = 32'h000000A5;

    @(negedge clk);
    check("rst_io_wait", {31'b0, io_wait_a}, 32'h0);
    check("rst_slv_en",  {24'b0, slv_en_a}, 32'h0);
    check("rst_slv_rd",  {31'b0, slv_rd_a}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rd_a = 1'b0;

    cyc_a(24'hFFFFDC, 1'b1, 1'b0);
    check("rst_esr_a", dout_a, 32'h0);

    cyc_a(24'hFFFFC0, 1'b1, 1'b0);
    check("zw_dout",    dout_a, 32'h12345678);
    check("zw_io_wait", {31'b0, io_wait_a}, 32'h0);
    check("zw_slv_en",  {24'b0, slv_en_a}, 32'h01);
    check("zw_slv_rd",  {31'b0, slv_rd_a}, 32'h1);
    check("zw_io_en",   {31'b0, io_en_a}, 32'h1);
    cyc_a(24'hFFFFC0, 1'b0, 1'b0);
    check("zw_rd_pulse", {31'b0, slv_rd_a}, 32'h0);
    check("zw_en_drop",  {24'b0, slv_en_a}, 32'h0);

    cyc_a(24'hFFFFC8, 1'b1, 1'b1);
    check("rw_slv_wr",   {31'b0, slv_wr_a}, 32'h1);
    check("rw_slv_rd",   {31'b0, slv_rd_a}, 32'h0);
    check("rw_slv_en",   {24'b0, slv_en_a}, 32'h04);
    check("rw_slv_dout", slv_dout_a, 32'hCAFEF00D);

    run_a(24'hFFFFD0, 3, 8'h00, nwait, nrd, dend);
    check("ack3_wait", nwait, 4);
    check("ack3_rd",   nrd, 1);
    check("ack3_dout", dend, 32'hA5);

    run_a(24'hFFFFD0, 15, 8'h00, nwait, nrd, dend);
    check("ackto_wait", nwait, 16);
    check("ackto_dout", dend, 32'hA5);
    cyc_a(24'hFFFFDC, 1'b1, 1'b0);
    check("ackto_esr", dout_a, 32'h0);

    run_a(24'hFFFFD0, -1, 8'h08, nwait, nrd, dend);
    check("tmo_wait", nwait, 16);
    check("tmo_rd",   nrd, 1);
    check("tmo_dout", dend, 32'h0);
    cyc_a(24'hFFFFDC, 1'b1, 1'b0);
    check("tmo_esr1", dout_a, 32'h80000401);

    run_a(24'hFFFFD0, -1, 8'h00, nwait, nrd, dend);
    cyc_a(24'hFFFFDC, 1'b1, 1'b0);
    check("tmo_esr2", dout_a, 32'h80000402);
    cyc_a(24'hFFFFDC, 1'b0, 1'b1);
    cyc_a(24'hFFFFDC, 1'b1, 1'b0);
    check("esr_clr_a", dout_a, 32'h0);
    cyc_a(24'hFFFFDC, 1'b0, 1'b0);

    cyc_b(24'hFFFFD8, 1'b1, 1'b0);
    check("b_unm_dout",    dout_b, 32'h0);
    check("b_unm_io_wait", {31'b0, io_wait_b}, 32'h0);
    check("b_unm_slv_en",  {26'b0, slv_en_b}, 32'h0);
    cyc_b(24'hFFFFD4, 1'b1, 1'b0);
    check("b_esr1", dout_b, 32'h80000601);
    check("b_esr_en", {26'b0, slv_en_b}, 32'h0);
    for (int i = 0; i < 300; i++) cyc_b(24'hFFFFFC, 1'b1, 1'b0);
    cyc_b(24'hFFFFD4, 1'b1, 1'b0);
    check("b_esr_sat", dout_b, 32'h800006FF);
    cyc_b(24'hFFFFD4, 1'b0, 1'b1);
    check("b_esr_wr_dout", slv_dout_b, 32'hCAFEF00D);
    cyc_b(24'hFFFFD4, 1'b1, 1'b0);
    check("b_esr_clr", dout_b, 32'h0);
    cyc_b(24'h0, 1'b0, 1'b0);

    cyc_a(24'hFFFFD0, 1'b1, 1'b0);
    check("rw0_io_wait", {31'b0, io_wait_a}, 32'h1);
    check("rw0_slv_en",  {24'b0, slv_en_a}, 32'h10);
    cyc_a(24'hFFFFD0, 1'b1, 1'b0);
    check("rw1_slv_rd",  {31'b0, slv_rd_a}, 32'h0);
    check("rw1_slv_en",  {24'b0, slv_en_a}, 32'h10);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rw2_rst_io_wait", {31'b0, io_wait_a}, 32'h0);
    check("rw2_rst_slv_en",  {24'b0, slv_en_a}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; rd_a = 1'b0;
    @(negedge clk);
    check("post_rst_io_wait", {31'b0, io_wait_a}, 32'h0);
    check("post_rst_slv_en",  {24'b0, slv_en_a}, 32'h0);
    check("post_rst_slv_rd",  {31'b0, slv_rd_a}, 32'h0);
    cyc_a(24'hFFFFC0, 1'b1, 1'b0);
    check("post_rst_idle", {31'b0, io_wait_a}, 32'h0);
    cyc_a(24'hFFFFDC, 1'b1, 1'b0);
    check("post_rst_esr", dout_a, 32'h0);

    cyc_a(24'h000100, 1'b1, 1'b0);
    check("nonio_io_en",   {31'b0, io_en_a}, 32'h0);
    check("nonio_slv_en",  {24'b0, slv_en_a}, 32'h0);
    check("nonio_dout",    dout_a, 32'h0);
    check("nonio_io_wait", {31'b0, io_wait_a}, 32'h0);
    cyc_a(24'h000100, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
